// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: an instruction-fetch port and a data port share one memory port.
// Contention alternates between the ports, and a wait counter aborts a request that is never acknowledged.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          m_req,
    output logic          m_we,
    output logic [3:0]    m_be,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t        state_q, state_d;
    logic          last_d_q, last_d_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] irdata_q, irdata_d;
    logic [DW-1:0] drdata_q, drdata_d;
    logic          irdy_q, irdy_d;
    logic          drdy_q, drdy_d;
    logic          err_q, err_d;
    logic          serve_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
            irdy_q   <= 1'b0;
            drdy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
            irdy_q   <= irdy_d;
            drdy_q   <= drdy_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        be_d     = be_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        irdy_d   = 1'b0;
        drdy_d   = 1'b0;
        err_d    = 1'b0;
        serve_d  = (state_q == SERVE_D);
        case (state_q)
            IDLE: begin
                // On contention the port that was not served last wins.
                if (d_req && (!i_req || !last_d_q)) begin
                    state_d = SERVE_D;
                    cnt_d   = '0;
                    we_d    = d_we;
                    be_d    = d_be;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                end else if (i_req) begin
                    state_d = SERVE_I;
                    cnt_d   = '0;
                    we_d    = 1'b0;
                    be_d    = 4'hF;
                    addr_d  = i_addr;
                    wdata_d = '0;
                end
            end
            SERVE_I, SERVE_D: begin
                if (m_ack) begin
                    state_d  = DONE;
                    last_d_d = serve_d;
                    drdy_d   = serve_d;
                    irdy_d   = !serve_d;
                    if (!serve_d)
                        irdata_d = m_rdata;
                    else if (!we_q)
                        drdata_d = m_rdata;
                end else if (cnt_q + 8'd1 == TMO) begin
                    // Ack never came: complete with zeroed read data and flag the abort.
                    state_d  = DONE;
                    last_d_d = serve_d;
                    drdy_d   = serve_d;
                    irdy_d   = !serve_d;
                    err_d    = 1'b1;
                    if (serve_d)
                        drdata_d = '0;
                    else
                        irdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign m_req   = (state_q == SERVE_I) || (state_q == SERVE_D);
    assign m_we    = we_q;
    assign m_be    = be_q;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;
    assign i_rdata = irdata_q;
    assign d_rdata = drdata_q;
    assign i_ready = irdy_q;
    assign d_ready = drdy_q;
    assign err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a memory responder model, a completion scoreboard and a linear step sequence.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [3:0]    d_be = 4'h0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] i_rdata, d_rdata, m_wdata;
    logic [DW-1:0] m_rdata = '0;
    logic [AW-1:0] m_addr;
    logic [3:0]    m_be;
    logic          i_ready, d_ready, m_req, m_we, err;
    logic          m_ack = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .err(err)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    typedef struct { bit port_d; logic [31:0] rdata; bit err; } exp_t;
    typedef struct { logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; } cmd_t;

    exp_t exp_q[$];
    cmd_t grant_q[$];

    // Memory responder: acks in the ack_delay-th m_req cycle, read data = mem_base ^ address.
    int          ack_delay = 1;
    bit          ack_never = 1'b0;
    bit          force_ack = 1'b0;
    logic [31:0] mem_base = '0;
    int          mcnt = 0;
    int          last_len = 0;
    cmd_t        cur;

    always @(negedge clk) begin
        if (m_req) begin
            mcnt++;
            if (mcnt == 1) begin
                cur = '{m_we, m_be, m_addr, m_wdata};
                grant_q.push_back(cur);
            end else begin
                chk("cmd_stable_addr", m_addr, cur.addr);
                chk("cmd_stable_wdata", m_wdata, cur.wdata);
                chk("cmd_stable_we_be", {27'b0, m_we, m_be}, {27'b0, cur.we, cur.be});
            end
            m_ack   = force_ack || (!ack_never && mcnt == ack_delay);
            m_rdata = mem_base ^ m_addr;
        end else begin
            if (mcnt != 0) last_len = mcnt;
            mcnt    = 0;
            m_ack   = force_ack;
            m_rdata = 32'hBAD0_BAD0;
        end
    end

    exp_t e;
    always @(negedge clk) begin
        if (i_ready || d_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ready", {30'b0, i_ready, d_ready}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("ready_port", {30'b0, i_ready, d_ready}, e.port_d ? 32'h1 : 32'h2);
                chk("ready_rdata", e.port_d ? d_rdata : i_rdata, e.rdata);
                chk("ready_err", 32'(err), 32'(e.err));
            end
        end else if (err) begin
            chk("err_without_ready", 32'(err), 32'h0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_any(output bit got_d, output int cyc);
        bit got;
        got = 1'b0; got_d = 1'b0; cyc = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            cyc++;
            got   = i_ready || d_ready;
            got_d = d_ready;
        end
        chk("ready_within_bound", 32'(got), 32'h1);
        step();
    endtask

    task automatic wait_ready(input bit want_d, output int cyc);
        bit gd;
        wait_any(gd, cyc);
        chk(want_d ? "served_port_d" : "served_port_i", 32'(gd), 32'(want_d));
    endtask

    task automatic chk_grant(input string tag, input cmd_t expc);
        cmd_t g;
        if (grant_q.size() == 0) begin
            chk({tag, "_present"}, 32'h0, 32'h1);
        end else begin
            g = grant_q.pop_front();
            chk({tag, "_addr"}, g.addr, expc.addr);
            chk({tag, "_wdata"}, g.wdata, expc.wdata);
            chk({tag, "_we_be"}, {27'b0, g.we, g.be}, {27'b0, expc.we, expc.be});
        end
    endtask

    initial begin
        int cyc;
        bit gd;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_m_req", 32'(m_req), 32'h0);
        chk("rst_m_cmd", {27'b0, m_we, m_be}, 32'h0);
        chk("rst_m_addr", m_addr, 32'h0);
        chk("rst_m_wdata", m_wdata, 32'h0);
        chk("rst_ready_err", {29'b0, i_ready, d_ready, err}, 32'h0);
        chk("rst_i_rdata", i_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        step();
        rst = 1'b1;

        // Single fetch, ack in the 2nd m_req cycle
        mem_base = 32'h2408_0045; ack_delay = 2;
        exp_q.push_back('{1'b0, 32'h2408_0005, 1'b0});
        i_addr = 32'h40; i_req = 1'b1;
        wait_ready(1'b0, cyc);
        i_req = 1'b0;
        chk("fetch_latency", 32'(cyc), 32'd4);
        chk_grant("fetch_cmd", '{1'b0, 4'hF, 32'h40, 32'h0});

        // Both held continuously: D,I,D,I with IDLE+DONE between completions
        mem_base = 32'hDEAD_0000; ack_delay = 1;
        i_addr = 32'h200; d_addr = 32'h300; d_we = 1'b0; d_be = 4'hF; d_wdata = '0;
        exp_q.push_back('{1'b1, 32'hDEAD_0300, 1'b0});
        exp_q.push_back('{1'b0, 32'hDEAD_0200, 1'b0});
        exp_q.push_back('{1'b1, 32'hDEAD_0300, 1'b0});
        exp_q.push_back('{1'b0, 32'hDEAD_0200, 1'b0});
        i_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ready((k % 2) == 0, cyc);
            chk("alt_gap", 32'(cyc), 32'd3);
        end
        i_req = 1'b0; d_req = 1'b0;
        for (int k = 0; k < 4; k++)
            chk_grant("alt_cmd", '{1'b0, 4'hF, (k % 2 == 0) ? 32'h300 : 32'h200, 32'h0});

        // Contention with a D write first, then I; the write leaves d_rdata alone
        d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hCAFE_F00D; d_be = 4'hF; i_addr = 32'h204;
        exp_q.push_back('{1'b1, 32'hDEAD_0300, 1'b0});
        exp_q.push_back('{1'b0, 32'hDEAD_0204, 1'b0});
        i_req = 1'b1; d_req = 1'b1;
        wait_ready(1'b1, cyc);
        d_req = 1'b0;
        wait_ready(1'b0, cyc);
        i_req = 1'b0;
        repeat (3) step();
        chk("contention_grants", 32'(grant_q.size()), 32'd2);
        chk_grant("cont_d_cmd", '{1'b1, 4'hF, 32'h100, 32'hCAFE_F00D});
        chk_grant("cont_i_cmd", '{1'b0, 4'hF, 32'h204, 32'h0});

        // Requester changes after grant are ignored
        d_we = 1'b0; d_addr = 32'h308; d_be = 4'hF; d_wdata = '0; ack_delay = 3;
        exp_q.push_back('{1'b1, 32'hDEAD_0308, 1'b0});
        d_req = 1'b1;
        step(); step();
        d_addr = 32'hFFFF_FFFC; d_wdata = 32'h5555_5555; d_be = 4'h3; d_we = 1'b1;
        wait_ready(1'b1, cyc);
        d_req = 1'b0; d_we = 1'b0; d_be = 4'hF;
        chk_grant("latched_cmd", '{1'b0, 4'hF, 32'h308, 32'h0});

        // Timeout with no ack at all
        ack_never = 1'b1; d_addr = 32'h80;
        exp_q.push_back('{1'b1, 32'h0, 1'b1});
        d_req = 1'b1;
        wait_ready(1'b1, cyc);
        d_req = 1'b0; ack_never = 1'b0;
        step(); step();
        chk("timeout_mreq_len", 32'(last_len), 32'd4);
        chk("timeout_latency", 32'(cyc), 32'd6);
        void'(grant_q.pop_front());

        // Ack in the terminal-count cycle wins
        ack_delay = 4; d_addr = 32'h84;
        exp_q.push_back('{1'b1, 32'hDEAD_0084, 1'b0});
        d_req = 1'b1;
        wait_ready(1'b1, cyc);
        d_req = 1'b0;
        step(); step();
        chk("tc_ack_mreq_len", 32'(last_len), 32'd4);
        void'(grant_q.pop_front());

        // Stray ack while idle changes nothing
        force_ack = 1'b1;
        step(); step();
        force_ack = 1'b0;
        step();
        chk("stray_ack_m_req", 32'(m_req), 32'h0);
        chk("stray_ack_i_rdata", i_rdata, 32'hDEAD_0204);
        chk("stray_ack_d_rdata", d_rdata, 32'hDEAD_0084);
        chk("stray_ack_grants", 32'(grant_q.size()), 32'h0);

        // Reset mid fetch: m_req drops at once, no ready; then a normal D write
        ack_never = 1'b1; i_addr = 32'h300;
        i_req = 1'b1;
        step(); step();
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_m_req", 32'(m_req), 32'h0);
        chk("midrst_rdata", i_rdata | d_rdata, 32'h0);
        chk("midrst_ready_err", {29'b0, i_ready, d_ready, err}, 32'h0);
        i_req = 1'b0; ack_never = 1'b0;
        step(); step();
        rst = 1'b1;
        chk_grant("midrst_i_cmd", '{1'b0, 4'hF, 32'h300, 32'h0});
        ack_delay = 1; d_we = 1'b1; d_addr = 32'h104; d_wdata = 32'h1234_5678; d_be = 4'h5;
        exp_q.push_back('{1'b1, 32'h0, 1'b0});
        d_req = 1'b1;
        wait_ready(1'b1, cyc);
        d_req = 1'b0;
        chk("post_rst_latency", 32'(cyc), 32'd3);
        chk_grant("post_rst_d_cmd", '{1'b1, 4'h5, 32'h104, 32'h1234_5678});

        repeat (3) step();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32: address width.
REQ-002 Parameter DW, default 32: data width.
REQ-003 Parameter TIMEOUT, default 255: maximum wait cycles for m_ack before abort; range 1..255.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 i_req  input  1  instruction-fetch read request.
REQ-007 i_addr  input  AW  fetch address.
REQ-008 i_rdata  output  DW  fetch read data.
REQ-009 i_ready  output  1  fetch completion, one-cycle pulse.
REQ-010 d_req  input  1  data-port request.
REQ-011 d_we  input  1  data write enable (1 = write).
REQ-012 d_be  input  4  data byte enables.
REQ-013 d_addr  input  AW  data address.
REQ-014 d_wdata  input  DW  data write value.
REQ-015 d_rdata  output  DW  data read value.
REQ-016 d_ready  output  1  data completion, one-cycle pulse.
REQ-017 m_req  output  1  memory request, held until ack or abort.
REQ-018 m_we / m_be / m_addr / m_wdata  output  1/4/AW/DW  memory command fields.
REQ-019 m_rdata  input  DW  memory read data, valid with m_ack.
REQ-020 m_ack  input  1  memory completion, one-cycle.
REQ-021 err  output  1  timeout pulse, coincident with the aborted port's ready.

Function
REQ-022 FSM states SHALL be IDLE, SERVE_I, SERVE_D, DONE; the single memory port serves one requester at a time.
REQ-023 IDLE: only i_req -> SERVE_I; only d_req -> SERVE_D; both -> port not served last (flag last_d; last_d=0 selects D); none -> stay.
REQ-024 On grant, the arbiter SHALL latch addr/we/be/wdata into command registers; requester input changes thereafter are ignored.
REQ-025 Fetch grant drives m_we=0, m_be=4'hF, m_wdata=0.
REQ-026 m_req SHALL be 1 in every SERVE_x cycle, 0 otherwise; command fields are stable while m_req=1.
REQ-027 Latency: req seen in IDLE at cycle 0 -> m_req=1 in cycle 1; m_ack in cycle k -> DONE with x_ready=1 in cycle k+1; min 3 cycles request to ready.
REQ-028 On m_ack in SERVE_x for a read: x_rdata <= m_rdata; writes leave d_rdata unchanged; x_rdata holds until next completion on that port.
REQ-029 last_d updates on each completion (1 after D, 0 after I).
REQ-030 DONE lasts one cycle, ready pulses for the served port only, then IDLE; requests are not sampled in DONE.
REQ-031 Requester rule: req held high through the cycle ready=1 and deasserted at that edge; req high in the following IDLE cycle is a new request.
REQ-032 8-bit wait counter cleared on grant, incremented each SERVE_x cycle without m_ack; at count == TIMEOUT without ack: drop m_req, go DONE, pulse x_ready and err; x_rdata <= {DW{1'b0}}.
REQ-033 m_ack in the same cycle as terminal count: ack wins, err=0, normal completion.
REQ-034 m_ack in IDLE or DONE SHALL be ignored (no state, data or ready change).

Reset
REQ-035 rst=0 SHALL immediately force: state IDLE, m_req=0, m_we=0, m_be=0, m_addr=0, m_wdata=0, i_ready=0, d_ready=0, err=0, i_rdata=0, d_rdata=0, last_d=0, counter=0.
REQ-036 Reset mid-transaction discards it with no ready pulse; after rst=1, first edge evaluates IDLE normally.

Verification
REQ-037 Fetch: i_req, i_addr=0x0000_0040; m_ack at 2nd m_req cycle, m_rdata=0x2408_0005 -> i_ready pulse 1 cycle, i_rdata=0x2408_0005, d_ready=0.
REQ-038 Contention: i_req and d_req both high from reset -> D served first (d_we=1, d_addr=0x100, d_wdata=0xCAFE_F00D, d_be=4'hF on m_*), then I without d_req re-grant; d_rdata unchanged.
REQ-039 Alternation: both held continuously for 4 transactions -> grant order D,I,D,I, one IDLE and one DONE cycle between.
REQ-040 Timeout: TIMEOUT=4, d_req read, m_ack never -> m_req high exactly 4 cycles, then d_ready=1, err=1, d_rdata=0.
REQ-041 Ack at terminal count: TIMEOUT=4, m_ack in 4th m_req cycle -> normal completion, err=0.
REQ-042 Reset in SERVE_I with m_req=1 -> m_req=0 asynchronously, no i_ready; post-reset d_req granted normally.
